// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_POS1 = 3'd1,
    SEL_POS2 = 3'd2,
    SEL_NEG1 = 3'd3,
    SEL_NEG2 = 3'd4
  } sel_e;

  // One digit per bit pair of the (WIDTH+2)-bit extended multiplier.
  function automatic int unsigned digit_count(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // Window {b[2i+1], b[2i], b[2i-1]} to multiple selection.
  function automatic sel_e decode_digit(input logic [2:0] digit);
    sel_e sel;
    unique case (digit)
      3'b001, 3'b010: sel = SEL_POS1;
      3'b011:         sel = SEL_POS2;
      3'b100:         sel = SEL_NEG2;
      3'b101, 3'b110: sel = SEL_NEG1;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_digit_select.sv
// Picks 0, A or 2A for one Booth digit; negation is left to the parent adder carry-in.
module booth_digit_select
  import booth_pkg::*;
#(
  parameter int unsigned EW = 34
) (
  input  logic [2:0]    digit_i,
  input  logic [EW-1:0] a_ext_i,
  output logic [EW:0]   mult_c,
  output logic          neg_c
);

  always_comb begin
    mult_c = '0;
    neg_c  = 1'b0;
    unique case (decode_digit(digit_i))
      SEL_POS1: mult_c = {a_ext_i[EW-1], a_ext_i};
      SEL_POS2: mult_c = {a_ext_i, 1'b0};
      SEL_NEG1: begin
        mult_c = {a_ext_i[EW-1], a_ext_i};
        neg_c  = 1'b1;
      end
      SEL_NEG2: begin
        mult_c = {a_ext_i, 1'b0};
        neg_c  = 1'b1;
      end
      default: mult_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one digit per cycle into a shared adder,
// Start/Busy/Done handshake, signed or unsigned operands.
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 nRst,
  input  logic                 Start,
  input  logic                 Sign,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int unsigned EW = WIDTH + 2;
  localparam int unsigned UW = WIDTH + 3;
  localparam int unsigned AW = 2 * WIDTH + 4;
  localparam int unsigned N  = digit_count(WIDTH);
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [EW:0]          mplr_q, mplr_d;
  logic [EW-1:0]        mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [EW:0]          mult;
  logic                 neg;
  logic [UW-1:0]        addend;
  logic [UW-1:0]        upper_sum;
  logic [AW-1:0]        acc_sum;
  logic [AW-1:0]        acc_shr;
  logic                 ext_bit;

  booth_digit_select #(.EW(EW)) u_sel (
    .digit_i (mplr_q[2:0]),
    .a_ext_i (mcand_q),
    .mult_c  (mult),
    .neg_c   (neg)
  );

  // Add (or subtract) the selected multiple into the top of the accumulator.
  assign addend    = mult ^ {UW{neg}};
  assign upper_sum = acc_q[AW-1 -: UW] + addend + UW'(neg);
  assign acc_sum   = {upper_sum, acc_q[AW-UW-1:0]};
  assign acc_shr   = AW'($signed(acc_sum) >>> 2);
  assign ext_bit   = 1'b0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          mcand_d = {{2{Sign & A[WIDTH-1]}}, A};
          mplr_d  = {{2{Sign & B[WIDTH-1]}}, B, ext_bit};
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = acc_shr;
        mplr_d = {{2{mplr_q[EW]}}, mplr_q[EW:2]};
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        // Last digit is not shifted, so the product sits one bit above the LSB.
        if (cnt_q == LAST) begin
          prod_d  = acc_sum[2*WIDTH:1];
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Product = prod_q;

endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Iterative radix-4 Booth multiplier for the MIPS datapath, parametrised in operand width, with signed and unsigned modes. It recodes one 3-bit Booth digit per cycle, selects 0, ±A or ±2A, and accumulates, replacing a combinational partial-product array with a shared single adder. A Start/Busy/Done handshake connects it to the MULT/MULTU control path, and the result feeds HI/LO.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4
- Clk  in  1  rising-edge clock
- nRst  in  1  asynchronous active-low reset
- Start  in  1  request; accepted only in IDLE or DONE
- Sign  in  1  1 = signed operands, 0 = unsigned; sampled with Start
- A  in  WIDTH  multiplicand; sampled with Start
- B  in  WIDTH  multiplier; sampled with Start
- Busy  out  1  high while iterating
- Done  out  1  one-cycle pulse when Product updates
- Product  out  2*WIDTH  result; held until the next Done

## Operation
- Extension: A and B are each extended to WIDTH+2 bits. Signed mode uses sign extension; unsigned mode uses zero extension. This lets one datapath serve both modes.
- Digit count: N = WIDTH/2 + 1 digits (17 when WIDTH=32).
- Digit window: each digit is taken from {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0.
- Digit mapping:
  - 000 and 111 → 0
  - 001 and 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101 and 110 → −A
- Negation: two's complement of the extended multiple, computed as invert plus carry-in 1.
- Accumulator:
  - 2*WIDTH+4 bits wide.
  - Each cycle the selected multiple is added to the upper WIDTH+3 bits, then the accumulator and multiplier shift arithmetically right by 2.
  - All arithmetic is two's complement. Overflow in the top guard bits is discarded.
- Result: Product is the low 2*WIDTH bits of the exact product A×B under the selected mode.
- State machine:
  - IDLE: Start → RUN (load operands, clear accumulator, iteration counter = 0).
  - RUN: counter increments each cycle. At counter = N−1 → DONE, and Product is registered.
  - DONE: Done = 1. Start → RUN (back-to-back accepted); otherwise → IDLE.
- Busy = (state == RUN).
- Start while RUN is ignored. The in-flight operation completes unaffected.
- Sign, A and B are don't-care except in the Start cycle.

## Timing
- Reset values: state IDLE, Busy 0, Done 0, Product 0, accumulator 0, counter 0.
- Reset is asynchronous. nRst low at any point, including mid-RUN, aborts the operation immediately.
  - After reset, no Done is produced for the aborted operation.
  - Product reads 0.
- Latency: Start sampled at edge k.
  - Busy is high on cycles k+1 … k+N.
  - Done is high and Product is valid on cycle k+N+1, which is k+18 for WIDTH=32.
- Throughput: with Start held high in the DONE cycle, a new operation begins every N+1 cycles.
- Product changes only on the edge entering DONE. It is stable at all other times.

## Structure
- Shared package booth_pkg:
  - state enum {IDLE, RUN, DONE}
  - Booth digit select encoding (ZERO, POS1, POS2, NEG1, NEG2)
  - function for digit count from WIDTH
- Sub-module booth_digit_select. This is combinational and parametrised on WIDTH+2.
  - Inputs: 3-bit digit and extended A.
  - Outputs: the selected multiple (0/A/2A, pre-negation) and a negate flag.
  - Negation happens as the adder carry-in in the parent.
- Parent module holds the FSM, counter, accumulator/multiplier shift register and Product register.

## Test plan
- Signed, WIDTH=32, A=−3 (0xFFFFFFFD), B=5:
  - Start pulse → Done exactly 18 cycles later.
  - Product = 0xFFFFFFFFFFFFFFF1.
  - Busy high for 17 cycles.
- Unsigned, A=B=0xFFFFFFFF → Product = 0xFFFFFFFE00000001.
  - Repeat with Sign=1 → Product = 0x0000000000000001.
- Signed corner: A=B=0x80000000 → Product = 0x4000000000000000.
  - Also A=0x80000000, B=0x7FFFFFFF → Product = 0xC000000080000000.
- Start pulses during RUN are ignored:
  - Exactly one Done occurs.
  - Product matches the first operands.
  - Then Start held high in the DONE cycle → second result 18 cycles after the first Done.
- Reset mid-RUN:
  - nRst low on cycle k+8 → Busy, Done and Product go to 0 immediately.
  - No Done follows.
  - A new Start after release gives the correct result.
- Random regression at WIDTH=8 and WIDTH=32, both modes, 10k vectors, checked against a reference model.
